// File: rtl/pixel_window_gen.sv
// 3x3 sliding-window generator for a raster pixel stream: two line buffers feed a
// registered neighbourhood window with valid strobe, centre coordinates and frame_done.
module pixel_window_gen #(
   parameter int PIX_BITS   = 8,
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 6,
   parameter int CNT_BITS   = 4
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  clear,
   input  logic                  pixel_valid,
   input  logic [PIX_BITS-1:0]   pixel_in,
   output logic [9*PIX_BITS-1:0] window_out,
   output logic                  window_valid,
   output logic [CNT_BITS-1:0]   center_col,
   output logic [CNT_BITS-1:0]   center_row,
   output logic                  frame_done
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FILL   = 2'd1;
   localparam logic [1:0] ACTIVE = 2'd2;

   localparam logic [CNT_BITS-1:0] COL_LAST = CNT_BITS'(IMG_WIDTH - 1);
   localparam logic [CNT_BITS-1:0] ROW_LAST = CNT_BITS'(IMG_HEIGHT - 1);
   localparam logic [CNT_BITS-1:0] ONE      = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] TWO      = CNT_BITS'(2);

   logic [1:0]          state;
   logic [CNT_BITS-1:0] col;
   logic [CNT_BITS-1:0] row;
   logic                accept;
   logic                col_last;
   logic                row_last;

   logic [PIX_BITS-1:0] lb1 [IMG_WIDTH];
   logic [PIX_BITS-1:0] lb2 [IMG_WIDTH];
   logic [PIX_BITS-1:0] win_p1 [9];
   logic                vld_p1;

   assign accept   = pixel_valid & ~clear;
   assign col_last = (col == COL_LAST);
   assign row_last = (row == ROW_LAST);

   // Line buffers: oldest entry of lb1 is (r-1,c), of lb2 is (r-2,c); contents need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[0] <= pixel_in;
         lb2[0] <= lb1[IMG_WIDTH-1];
         for (int k = 1; k < IMG_WIDTH; k++) begin
            lb1[k] <= lb1[k-1];
            lb2[k] <= lb2[k-1];
         end
      end
   end

   // Stage p1: position counters, FSM and registered window outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         vld_p1     <= 1'b0;
         center_col <= '0;
         center_row <= '0;
         frame_done <= 1'b0;
         for (int k = 0; k < 9; k++) win_p1[k] <= '0;
      end else if (clear) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         vld_p1     <= 1'b0;
         center_col <= '0;
         center_row <= '0;
         frame_done <= 1'b0;
         for (int k = 0; k < 9; k++) win_p1[k] <= '0;
      end else if (pixel_valid) begin
         col        <= col_last ? '0 : col + ONE;
         if (col_last) row <= row_last ? '0 : row + ONE;
         vld_p1     <= (row >= TWO) && (col >= TWO);
         center_col <= col - ONE;
         center_row <= row - ONE;
         frame_done <= col_last && row_last;
         for (int i = 0; i < 3; i++) begin
            win_p1[3*i]   <= win_p1[3*i+1];
            win_p1[3*i+1] <= win_p1[3*i+2];
         end
         win_p1[2] <= lb2[IMG_WIDTH-1];
         win_p1[5] <= lb1[IMG_WIDTH-1];
         win_p1[8] <= pixel_in;
         case (state)
            IDLE:    state <= FILL;
            FILL:    if (col_last && row == ONE) state <= ACTIVE;
            ACTIVE:  if (col_last && row_last) state <= IDLE;
            default: state <= IDLE;
         endcase
      end else begin
         vld_p1     <= 1'b0;
         frame_done <= 1'b0;
      end
   end

   assign window_valid = vld_p1;

   for (genvar g = 0; g < 9; g++) begin : g_pack
      assign window_out[PIX_BITS*g +: PIX_BITS] = win_p1[g];
   end

endmodule

// File: tb/tb_pixel_window_gen.sv
// Directed bench for pixel_window_gen on an 8x6 frame with pixel value r*8+c.
module tb_pixel_window_gen;

   logic        clk;
   logic        n_rst;
   logic        clear;
   logic        pixel_valid;
   logic [7:0]  pixel_in;
   logic [71:0] window_out;
   logic        window_valid;
   logic [3:0]  center_col;
   logic [3:0]  center_row;
   logic        frame_done;

   int checks;
   int failures;

   pixel_window_gen #(
      .PIX_BITS(8), .IMG_WIDTH(8), .IMG_HEIGHT(6), .CNT_BITS(4)
   ) dut (
      .clk(clk), .n_rst(n_rst), .clear(clear), .pixel_valid(pixel_valid),
      .pixel_in(pixel_in), .window_out(window_out), .window_valid(window_valid),
      .center_col(center_col), .center_row(center_row), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [71:0] exp_win(input int r, input int c);
      logic [71:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[8*(3*i+j) +: 8] = 8'((r - 2 + i) * 8 + (c - 2 + j));
      return w;
   endfunction

   task automatic step(input logic v, input logic [7:0] p, input logic clr);
      pixel_valid = v;
      pixel_in    = p;
      clear       = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0; clear = 1'b0; pixel_valid = 1'b0; pixel_in = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({window_out, window_valid, center_col, center_row, frame_done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got win=%h v=%b cc=%0d cr=%0d fd=%b want all zero",
                  window_out, window_valid, center_col, center_row, frame_done);
      end
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   // Feeds one full frame, optionally with an idle cycle after every pixel.
   task automatic test_frame(input int gap);
      int vcount;
      int first_idx;
      int idx;
      logic ev;
      logic [71:0] held;
      logic [3:0] hc, hr;
      vcount = 0;
      first_idx = -1;
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 8; c++) begin
            idx = r * 8 + c;
            step(1'b1, 8'(idx), 1'b0);
            ev = (r >= 2) && (c >= 2);
            checks++;
            if (window_valid !== ev) begin
               failures++;
               $display("FAIL frame_valid px=%0d got %b want %b", idx, window_valid, ev);
            end
            checks++;
            if (frame_done !== (idx == 47)) begin
               failures++;
               $display("FAIL frame_done px=%0d got %b want %b", idx, frame_done, idx == 47);
            end
            if (ev) begin
               vcount++;
               if (first_idx < 0) first_idx = idx;
               checks++;
               if (window_out !== exp_win(r, c)) begin
                  failures++;
                  $display("FAIL frame_window px=%0d got %h want %h", idx, window_out, exp_win(r, c));
               end
               checks++;
               if (center_col !== 4'(c - 1) || center_row !== 4'(r - 1)) begin
                  failures++;
                  $display("FAIL frame_center px=%0d got (%0d,%0d) want (%0d,%0d)",
                           idx, center_row, center_col, r - 1, c - 1);
               end
            end
            if (idx == 18) begin
               checks++;
               if (window_out !== 72'h12_11_10_0A_09_08_02_01_00 || center_row !== 4'd1 || center_col !== 4'd1) begin
                  failures++;
                  $display("FAIL first_window got %h (%0d,%0d) want 121110_0a0908_020100 (1,1)",
                           window_out, center_row, center_col);
               end
            end
            if (idx == 47) begin
               checks++;
               if (window_out !== 72'h2F2E2D_272625_1F1E1D || center_row !== 4'd4 || center_col !== 4'd6) begin
                  failures++;
                  $display("FAIL last_window got %h (%0d,%0d) want 2f2e2d_272625_1f1e1d (4,6)",
                           window_out, center_row, center_col);
               end
            end
            if (gap != 0) begin
               held = window_out; hc = center_col; hr = center_row;
               step(1'b0, 8'hAA, 1'b0);
               checks++;
               if (window_valid !== 1'b0 || frame_done !== 1'b0 || window_out !== held
                   || center_col !== hc || center_row !== hr) begin
                  failures++;
                  $display("FAIL gap_hold px=%0d got v=%b fd=%b win=%h want v=0 fd=0 win=%h",
                           idx, window_valid, frame_done, window_out, held);
               end
            end
         end
      end
      checks++;
      if (vcount != 24) begin
         failures++;
         $display("FAIL valid_count got %0d want 24", vcount);
      end
      checks++;
      if (first_idx != 18) begin
         failures++;
         $display("FAIL first_valid_index got %0d want 18", first_idx);
      end
   endtask

   task automatic test_clear();
      for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b1, 8'd20, 1'b1);
      checks++;
      if (window_valid !== 1'b0 || window_out !== '0 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL clear_outputs got v=%b win=%h fd=%b want v=0 win=0 fd=0",
                  window_valid, window_out, frame_done);
      end
      test_frame(0);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 28; i++) step(1'b1, 8'(i), 1'b0);
      pixel_valid = 1'b0;
      #2;
      n_rst = 1'b0;
      #1;
      checks++;
      if ({window_out, window_valid, center_col, center_row, frame_done} !== '0) begin
         failures++;
         $display("FAIL async_reset got win=%h v=%b cc=%0d cr=%0d fd=%b want all zero",
                  window_out, window_valid, center_col, center_row, frame_done);
      end
      @(negedge clk);
      n_rst = 1'b1;
      test_frame(0);
   endtask

   task automatic test_back_to_back();
      test_frame(0);
      test_frame(0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_frame(0);
      test_frame(1);
      test_clear();
      test_async_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation exceeded time limit");
      $fatal(1);
   end

endmodule
